matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
Sequencer for the 3x3 matrix-multiplier datapath/controller pair. It accepts a valid/ready element stream and clears the memories. It then steers N*N beats into the W memory and N*N beats into the X memory, releases the MAC and holds ld until the multiplier controller reports done. It replaces bench-driven ldw/ldx/ld/clear sequencing and is the block that sits between a host stream and the datapath.

Parameters:
N, 3, matrix dimension; beats per matrix = N*N
DW, 4, element width of in_data/data_in
WDOG_CYC, 255, compute watchdog limit in cycles (used only with MATMUL_SEQ_WDOG_EN)

Ports:
clk  in  1  clock, all logic on rising edge
clear  in  1  reset, synchronous, active-high
start  in  1  request a job; sampled only in IDLE
in_valid  in  1  element stream valid
in_data  in  DW  element, row-major, W first then X
in_ready  out  1  sequencer accepts element this cycle
data_in  out  DW  to datapath; combinational copy of in_data
ldw  out  1  datapath W-memory load strobe
ldx  out  1  datapath X-memory load strobe
ld  out  1  run strobe to datapath/controller
clear_mem  out  1  datapath memory clear
clear_mac  out  1  datapath MAC clear
mm_done  in  1  done from multiplier controller
busy  out  1  high in every state except IDLE
job_done  out  1  one-cycle pulse on completion
timeout  out  1  one-cycle pulse on watchdog expiry; constant 0 without macro

Behaviour:
- States: IDLE, CLR, LOAD_W, LOAD_X, COMPUTE, FIN. State register, beat counter and registered outputs update on the clk edge.
- Reset (clear=1): state IDLE, cnt 0, clear_mem=1, clear_mac=1, ld=0, busy=0, job_done=0, timeout=0. ldw, ldx and in_ready are 0 because they are decoded from IDLE. clear has priority over every other input, including start in the same cycle. clear mid-job aborts immediately and leaves no partial state.
- IDLE: in_ready=0, ld=0. clear_mem holds its last value; clear_mac stays 0 after a completed job so the results remain readable. start=1 moves to CLR.
- CLR (exactly 1 cycle): clear_mem=1, clear_mac=1, cnt<=0, then LOAD_W. in_ready first rises 2 cycles after start is sampled.
- LOAD_W: clear_mem=0, in_ready=1.
  - ldw = in_valid (combinational).
  - A beat is accepted when in_valid&in_ready; cnt increments per beat.
  - A stall (in_valid=0) holds cnt and drives ldw=0.
  - The beat with cnt==N*N-1 sets cnt<=0 and moves to LOAD_X.
- LOAD_X: identical rules with ldx, moving to COMPUTE after N*N beats. The W->X switch has no bubble: beat N*N is accepted in the first LOAD_X cycle.
- COMPUTE: in_ready=0, clear_mac=0, ld=1 (registered; high from the first COMPUTE cycle). mm_done=1 moves to FIN. mm_done is ignored in all other states.
- FIN (1 cycle): ld=0, job_done=1, then IDLE.
- start outside IDLE is ignored. in_valid outside the LOAD states is ignored and never strobes ldw/ldx.
- Counter width: clog2(N*N); no wrap beyond N*N-1.
- Job latency = 1 + 2*N*N + (compute cycles) + 1 for an unstalled stream.

Optional Feature:
MATMUL_SEQ_WDOG_EN: a wdog counter (width clog2(WDOG_CYC+1)) clears on entering COMPUTE and increments each COMPUTE cycle. If it reaches WDOG_CYC without mm_done, the block drops ld, pulses timeout for 1 cycle and returns to IDLE without job_done. If mm_done arrives in the same cycle the count reaches WDOG_CYC, mm_done wins. Without the macro there is no counter, timeout is tied 0, and COMPUTE waits indefinitely.

Decomposition:
- matmul_pkg: state enum, default N/DW, BEATS=N*N constant, counter-width function. Shared with the datapath and controller.
- One sub-module, matmul_beat_cnt: enable/clear counter with terminal-count flag, used for the beat count and the watchdog.

Test Plan:
- Reset: hold clear 3 cycles -> clear_mem=1, clear_mac=1, ld/ldw/ldx/in_ready/busy/job_done=0.
- Nominal with the real datapath:
  - Stimulus: start, then stream W=2,3,4,5,6,8,7,4,2 and X=9,3,0,8,5,3,6,9,7 with in_valid constantly 1.
  - Required: ldw high exactly 9 cycles, then ldx exactly 9 cycles; ld rises after the last beat; job_done pulses once.
  - Result, row-major: 66 57 37 / 141 117 74 / 107 59 26.
- Stall: drop in_valid every other cycle -> ldw/ldx pulse only on valid cycles; memory contents equal the nominal case; cnt never skips.
- Abort: assert clear on the 5th X beat -> IDLE next cycle, clear_mem=1, clear_mac=1; a fresh job afterwards completes correctly.
- Ignored inputs:
  - start pulsed in LOAD_W and COMPUTE -> no effect.
  - mm_done pulsed in LOAD_X -> no transition.
  - start with clear in the same cycle -> stays IDLE.
- Watchdog (macro defined, WDOG_CYC=20): mm_done held 0 -> timeout pulses after 20 COMPUTE cycles, ld=0, no job_done.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the 3x3 matrix-multiplier block set.
// Used by the sequencer, datapath and multiplier controller.
package matmul_pkg;

  localparam int N_DEF  = 3;
  localparam int DW_DEF = 4;
  localparam int BEATS  = N_DEF * N_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_W,
    S_LOAD_X,
    S_COMPUTE,
    S_FIN
  } seq_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Element stream from the host into the sequencer.
// The master drives valid/data, the slave answers with ready.
interface matmul_seq_ctrl_if
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/matmul_beat_cnt.sv
// Enable/clear up-counter with a terminal-count flag at MAX-1.
// Clear wins over enable.
module matmul_beat_cnt
  import matmul_pkg::*;
#(
  parameter int MAX = BEATS,
  parameter int W   = cnt_w(MAX)
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(MAX - 1));

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Job sequencer: clear, load W, load X, run until done.
// Optional compute watchdog: MATMUL_SEQ_WDOG_EN.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int DW       = DW_DEF,
  parameter int WDOG_CYC = 255
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  matmul_seq_ctrl_if.slave strm,
  output logic [DW-1:0] data_in,
  output logic          ldw,
  output logic          ldx,
  output logic          ld,
  output logic          clear_mem,
  output logic          clear_mac,
  input  logic          mm_done,
  output logic          busy,
  output logic          job_done,
  output logic          timeout
);

  localparam int NB = N * N;

  seq_state_t state;
  logic       loading;
  logic       beat;
  logic       beat_tc;
  logic       wdog_tc;

  assign loading       = (state == S_LOAD_W) | (state == S_LOAD_X);
  assign strm.in_ready = loading;
  assign beat          = loading & strm.in_valid;
  assign ldw           = (state == S_LOAD_W) & strm.in_valid;
  assign ldx           = (state == S_LOAD_X) & strm.in_valid;
  assign data_in       = strm.in_data;

  matmul_beat_cnt #(
    .MAX (NB),
    .W   (cnt_w(NB))
  ) u_beat (
    .clk (clk),
    .clr (clear | (state == S_CLR) | (beat & beat_tc)),
    .en  (beat),
    .tc  (beat_tc)
  );

`ifdef MATMUL_SEQ_WDOG_EN
  matmul_beat_cnt #(
    .MAX (WDOG_CYC),
    .W   (cnt_w(WDOG_CYC + 1))
  ) u_wdog (
    .clk (clk),
    .clr (clear | (state != S_COMPUTE)),
    .en  (state == S_COMPUTE),
    .tc  (wdog_tc)
  );
`else
  logic unused_wdog;
  assign unused_wdog = |WDOG_CYC;
  assign wdog_tc     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      clear_mem <= 1'b1;
      clear_mac <= 1'b1;
      ld        <= 1'b0;
      busy      <= 1'b0;
      job_done  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      job_done <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLR;
            clear_mem <= 1'b1;
            clear_mac <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_CLR: begin
          state     <= S_LOAD_W;
          clear_mem <= 1'b0;
        end
        S_LOAD_W: begin
          if (beat & beat_tc) state <= S_LOAD_X;
        end
        S_LOAD_X: begin
          if (beat & beat_tc) begin
            state     <= S_COMPUTE;
            clear_mac <= 1'b0;
            ld        <= 1'b1;
          end
        end
        S_COMPUTE: begin
          // mm_done takes precedence over a simultaneous watchdog expiry
          if (mm_done) begin
            state    <= S_FIN;
            ld       <= 1'b0;
            job_done <= 1'b1;
          end else if (wdog_tc) begin
            state   <= S_IDLE;
            ld      <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ld    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed and randomized bench for matmul_seq_ctrl with a datapath memory model.
// Define MATMUL_SEQ_WDOG_EN to also exercise the compute watchdog.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  localparam int B = 9;
`ifdef MATMUL_SEQ_WDOG_EN
  localparam int TB_WDOG = 20;
`else
  localparam int TB_WDOG = 255;
`endif

  logic       clk = 1'b0;
  logic       clear, start, mm_done;
  logic [3:0] data_in;
  logic       ldw, ldx, ld, clear_mem, clear_mac;
  logic       busy, job_done, timeout;

  matmul_seq_ctrl_if #(.DW(4)) strm_if ();

  matmul_seq_ctrl #(
    .N(3), .DW(4), .WDOG_CYC(TB_WDOG)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .strm      (strm_if),
    .data_in   (data_in),
    .ldw       (ldw),
    .ldx       (ldx),
    .ld        (ld),
    .clear_mem (clear_mem),
    .clear_mac (clear_mac),
    .mm_done   (mm_done),
    .busy      (busy),
    .job_done  (job_done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // datapath memory model and event tallies, sampled mid-cycle
  int ncyc = 0;
  int wmem [B];
  int xmem [B];
  int wi = 0, xi = 0;
  int ldw_n, ldx_n, ld_n, jd_n, to_n, bad;
  int ld_rise, rdy_first, jd_cyc, to_cyc;
  logic ld_prev = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (clear_mem) begin
      wi = 0;
      xi = 0;
    end
    if (ldw) begin
      if (wi < B) wmem[wi] = int'(data_in);
      wi++;
      ldw_n++;
      if (!strm_if.in_valid) bad++;
    end
    if (ldx) begin
      if (xi < B) xmem[xi] = int'(data_in);
      xi++;
      ldx_n++;
      if (!strm_if.in_valid) bad++;
    end
    if (ld) ld_n++;
    if (ld && !ld_prev) ld_rise = ncyc;
    ld_prev = ld;
    if (strm_if.in_ready && rdy_first < 0) rdy_first = ncyc;
    if (job_done) begin
      jd_n++;
      jd_cyc = ncyc;
    end
    if (timeout) begin
      to_n++;
      to_cyc = ncyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_tally();
    ldw_n = 0; ldx_n = 0; ld_n = 0; jd_n = 0; to_n = 0; bad = 0;
    ld_rise = -1; rdy_first = -1; jd_cyc = -1; to_cyc = -1;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = ncyc;
  endtask

  task automatic stream(input int w[B], input int x[B], input bit stall,
                        input bit pokes, input int abort_at,
                        output int last, output int done_n);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit acc;
    last = -1;
    while (idx < 2 * B && guard < 200) begin
      strm_if.in_valid = stall ? ph : 1'b1;
      ph = !ph;
      strm_if.in_data = (idx < B) ? w[idx][3:0] : x[idx - B][3:0];
      start   = pokes && (idx == 3);
      mm_done = pokes && (idx == 12);
      if (idx == abort_at) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        strm_if.in_valid = 1'b0;
        done_n = idx;
        return;
      end
      @(negedge clk);
      acc = strm_if.in_valid && strm_if.in_ready;
      tick();
      if (acc) begin
        if (idx == 2 * B - 1) last = ncyc;
        idx++;
      end
      guard++;
    end
    strm_if.in_valid = 1'b0;
    start   = 1'b0;
    mm_done = 1'b0;
    done_n  = idx;
  endtask

  task automatic run_job(input string tg, input int w[B], input int x[B],
                         input bit stall, input int k, input bit pokes);
    int s, last, n, g, werr, xerr;
    clr_tally();
    do_start(s);
    stream(w, x, stall, pokes, -1, last, n);
    chk({tg, "_beats"}, n, 2 * B);
    g = 0;
    while (!ld && g < 20) begin
      tick();
      g++;
    end
    chk({tg, "_ld_up"}, ld, 1);
    for (int i = 1; i < k; i++) begin
      start = pokes && (i == 1);
      tick();
    end
    start = 1'b0;
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    tick();
    tick();
    werr = 0;
    xerr = 0;
    for (int i = 0; i < B; i++) begin
      if (wmem[i] != w[i]) werr++;
      if (xmem[i] != x[i]) xerr++;
    end
    chk({tg, "_ldw_n"}, ldw_n, B);
    chk({tg, "_ldx_n"}, ldx_n, B);
    chk({tg, "_strobe_wo_valid"}, bad, 0);
    chk({tg, "_wmem_err"}, werr, 0);
    chk({tg, "_xmem_err"}, xerr, 0);
    chk({tg, "_ld_after_last"}, ld_rise, last + 1);
    chk({tg, "_ld_cycles"}, ld_n, k);
    chk({tg, "_job_done_n"}, jd_n, 1);
    chk({tg, "_busy_end"}, busy, 0);
    chk({tg, "_clear_mac_end"}, clear_mac, 0);
    if (!stall) begin
      chk({tg, "_rdy_first"}, rdy_first, s + 2);
      chk({tg, "_latency"}, jd_cyc, s + 2 * B + k + 2);
    end
  endtask

  int nw [B] = '{2, 3, 4, 5, 6, 8, 7, 4, 2};
  int nx [B] = '{9, 3, 0, 8, 5, 3, 6, 9, 7};
  int nres [B] = '{66, 57, 37, 141, 117, 74, 107, 59, 26};
  int rw [B];
  int rx [B];

  function automatic int res_err();
    int e = 0;
    int acc;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int j = 0; j < 3; j++) acc += wmem[r * 3 + j] * xmem[j * 3 + c];
        if (acc != nres[r * 3 + c]) e++;
      end
    return e;
  endfunction

  initial begin
    int s, last, n;
    clear = 1'b1;
    start = 1'b0;
    mm_done = 1'b0;
    strm_if.in_valid = 1'b0;
    strm_if.in_data = 4'h0;
    clr_tally();
    repeat (3) tick();
    chk("rst_clear_mem", clear_mem, 1);
    chk("rst_clear_mac", clear_mac, 1);
    chk("rst_strobes", {ld, ldw, ldx, strm_if.in_ready}, 0);
    chk("rst_status", {busy, job_done, timeout}, 0);
    clear = 1'b0;
    tick();

    strm_if.in_data = 4'hA;
    #1;
    chk("data_in_copy", data_in, 4'hA);

    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    tick();
    chk("start_clear_busy", busy, 0);
    chk("start_clear_rdy", strm_if.in_ready, 0);

    run_job("nom", nw, nx, 1'b0, 5, 1'b0);
    chk("nom_result_err", res_err(), 0);

    run_job("stall", nw, nx, 1'b1, 3, 1'b0);
    chk("stall_result_err", res_err(), 0);

    clr_tally();
    do_start(s);
    stream(nw, nx, 1'b0, 1'b0, B + 4, last, n);
    chk("abort_busy", busy, 0);
    chk("abort_clears", {clear_mem, clear_mac}, 2'b11);
    chk("abort_strobes", {ld, strm_if.in_ready, ldw, ldx}, 0);
    tick();
    chk("abort_idle", busy, 0);

    run_job("fresh", nw, nx, 1'b0, 2, 1'b0);
    chk("fresh_result_err", res_err(), 0);

    run_job("ign", nw, nx, 1'b0, 4, 1'b1);
    chk("ign_result_err", res_err(), 0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < B; i++) begin
        rw[i] = int'($urandom_range(0, 15));
        rx[i] = int'($urandom_range(0, 15));
      end
      run_job($sformatf("rnd%0d", t), rw, rx, t[0],
              int'($urandom_range(1, 7)), 1'b0);
    end

`ifdef MATMUL_SEQ_WDOG_EN
    clr_tally();
    do_start(s);
    stream(nw, nx, 1'b0, 1'b0, -1, last, n);
    for (int i = 0; i < 60 && to_n == 0; i++) tick();
    tick();
    chk("wdog_to_n", to_n, 1);
    chk("wdog_to_cyc", to_cyc, s + 2 * B + TB_WDOG + 2);
    chk("wdog_ld", ld, 0);
    chk("wdog_no_done", jd_n, 0);
    chk("wdog_busy", busy, 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
